// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
//   Run-control sequencer for the soft RISC CPU. Turns the 100 MHz board
//   clock into a single-cycle clock-enable pulse for the CPU core in one of
//   four modes: halted, single-step, slow run (SLOW_DIV cycles per pulse)
//   and fast run (FAST_DIV cycles per pulse). A CPU-raised halt_req locks
//   the sequencer until the resume button is pressed.
//
// Ports
//   clk_100mhz  in   board clock, rising edge
//   reset       in   asynchronous active-low reset
//   mode_sel    in   [1:0] 00 halt, 01 step, 10 slow run, 11 fast run
//   step_req    in   step button level (rising edge acts)
//   halt_req    in   CPU lock-halt request level
//   resume      in   resume button level (rising edge acts)
//   cpu_ce      out  registered one-cycle CPU clock-enable pulse
//   state       out  [1:0] 00 HALT, 01 RUN, 10 STEP, 11 LOCK
//   step_count  out  [15:0] pulses issued, wraps modulo 2^16
//   tick_led    out  toggles on every pulse

module cpu_run_ctrl #(
    parameter int SLOW_DIV = 100_000_000,
    parameter int FAST_DIV = 100_000,
    parameter int CNT_W    = 27
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [1:0]  mode_sel,
    input  logic        step_req,
    input  logic        halt_req,
    input  logic        resume,
    output logic        cpu_ce,
    output logic [1:0]  state,
    output logic [15:0] step_count,
    output logic        tick_led
);

    typedef enum logic [1:0] {
        HALT = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        LOCK = 2'b11
    } state_t;

    // Terminal counts: the divider fires when the counter reaches DIV-1.
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic             resume_q;
    logic [CNT_W-1:0] div_last;
    logic             step_rise;
    logic             resume_rise;

    // Divider length follows mode_sel[0] every cycle, so a live speed
    // switch takes effect immediately.
    assign div_last    = mode_sel[0] ? FAST_LAST : SLOW_LAST;
    assign step_rise   = step_req & ~step_q;
    assign resume_rise = resume & ~resume_q;
    assign state       = st;

    always_ff @(posedge clk_100mhz or negedge reset) begin
        if (!reset) begin
            st         <= HALT;
            cnt        <= '0;
            step_q     <= 1'b0;
            resume_q   <= 1'b0;
            cpu_ce     <= 1'b0;
            step_count <= '0;
            tick_led   <= 1'b0;
        end else begin
            step_q   <= step_req;
            resume_q <= resume;
            cpu_ce   <= 1'b0;

            unique case (st)
                HALT: begin
                    if (halt_req) begin
                        st <= LOCK;
                    end else if (mode_sel[1]) begin
                        st  <= RUN;
                        cnt <= '0;
                    end else if (mode_sel == 2'b01 && step_rise) begin
                        // Pulse is launched on the transition so it is high
                        // for exactly the one cycle spent in STEP.
                        st         <= STEP;
                        cpu_ce     <= 1'b1;
                        step_count <= step_count + 16'd1;
                        tick_led   <= ~tick_led;
                    end
                end

                STEP: begin
                    // The pulse already issued; halt_req only picks the exit.
                    st <= halt_req ? LOCK : HALT;
                end

                RUN: begin
                    if (halt_req) begin
                        st  <= LOCK;
                        cnt <= '0;
                    end else if (!mode_sel[1]) begin
                        st  <= HALT;
                        cnt <= '0;
                    end else if (cnt >= div_last) begin
                        // >= so a slow->fast switch with a large residual
                        // count fires at once instead of wrapping.
                        cnt        <= '0;
                        cpu_ce     <= 1'b1;
                        step_count <= step_count + 16'd1;
                        tick_led   <= ~tick_led;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                LOCK: begin
                    // Resume always drops to HALT; a still-high halt_req
                    // re-locks from there on the following cycle.
                    if (resume_rise) st <= HALT;
                end

                default: st <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl. u_dut uses SLOW_DIV=10 / FAST_DIV=4;
// u_wrap uses FAST_DIV=1 to reach the 16-bit count wrap quickly.
// Inputs change 1 ns after a rising edge, outputs are checked there too.

module tb_cpu_run_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  mode_sel;
    logic        step_req;
    logic        halt_req;
    logic        resume;

    logic        cpu_ce,   w_cpu_ce;
    logic [1:0]  state,    w_state;
    logic [15:0] step_count, w_step_count;
    logic        tick_led, w_tick_led;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] ec;

    cpu_run_ctrl #(.SLOW_DIV(10), .FAST_DIV(4), .CNT_W(27)) u_dut (
        .clk_100mhz (clk),
        .reset      (reset),
        .mode_sel   (mode_sel),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .resume     (resume),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .step_count (step_count),
        .tick_led   (tick_led)
    );

    cpu_run_ctrl #(.SLOW_DIV(10), .FAST_DIV(1), .CNT_W(27)) u_wrap (
        .clk_100mhz (clk),
        .reset      (reset),
        .mode_sel   (mode_sel),
        .step_req   (step_req),
        .halt_req   (halt_req),
        .resume     (resume),
        .cpu_ce     (w_cpu_ce),
        .state      (w_state),
        .step_count (w_step_count),
        .tick_led   (w_tick_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        mode_sel = 2'b00;
        step_req = 1'b0;
        halt_req = 1'b0;
        resume   = 1'b0;
        ec       = 16'd0;

        // ---- 1: reset mid-cycle, then stay halted for 20 cycles
        #12 reset = 1'b0;
        #1;
        chk("rst_ce",    {31'd0, cpu_ce},   32'd0);
        chk("rst_state", {30'd0, state},    32'd0);
        chk("rst_count", {16'd0, step_count}, 32'd0);
        chk("rst_led",   {31'd0, tick_led}, 32'd0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            chk("idle_state", {30'd0, state},  32'd0);
            chk("idle_ce",    {31'd0, cpu_ce}, 32'd0);
        end

        // step_req edge in mode 00 does nothing
        step_req = 1'b1; cyc(1);
        chk("step_m00_ce",    {31'd0, cpu_ce}, 32'd0);
        chk("step_m00_state", {30'd0, state},  32'd0);
        step_req = 1'b0; cyc(1);

        // ---- 2: single step, held 5 cycles -> one pulse
        mode_sel = 2'b01;
        step_req = 1'b1; cyc(1);
        ec = 16'd1;
        chk("step1_ce",    {31'd0, cpu_ce},     32'd1);
        chk("step1_state", {30'd0, state},      32'd2);
        chk("step1_count", {16'd0, step_count}, {16'd0, ec});
        chk("step1_led",   {31'd0, tick_led},   32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("step1_hold_ce",    {31'd0, cpu_ce}, 32'd0);
            chk("step1_hold_state", {30'd0, state},  32'd0);
        end
        step_req = 1'b0; cyc(1);
        step_req = 1'b1; cyc(1);
        ec = 16'd2;
        chk("step2_ce",    {31'd0, cpu_ce},     32'd1);
        chk("step2_count", {16'd0, step_count}, {16'd0, ec});
        chk("step2_led",   {31'd0, tick_led},   32'd0);
        cyc(1);
        chk("step2_back",  {30'd0, state},      32'd0);
        step_req = 1'b0; cyc(1);

        // ---- 3: slow run, pulses at entry+10/+20/+30
        mode_sel = 2'b10; cyc(1);
        chk("run_entry", {30'd0, state}, 32'd1);
        for (int i = 1; i <= 35; i++) begin
            cyc(1);
            chk("slow_ce", {31'd0, cpu_ce}, (i % 10 == 0) ? 32'd1 : 32'd0);
        end
        ec = 16'd5;
        chk("slow_count", {16'd0, step_count}, {16'd0, ec});
        // counter is 5 here: leaving RUN gives no pulse
        mode_sel = 2'b00; cyc(1);
        chk("slow_exit_state", {30'd0, state},      32'd0);
        chk("slow_exit_ce",    {31'd0, cpu_ce},     32'd0);
        chk("slow_exit_count", {16'd0, step_count}, {16'd0, ec});

        // ---- 4: re-enter slow, switch to fast at counter 7
        mode_sel = 2'b10; cyc(1);
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            chk("reentry_ce", {31'd0, cpu_ce}, 32'd0);
        end
        mode_sel = 2'b11; cyc(1);
        ec = 16'd6;
        chk("switch_ce",    {31'd0, cpu_ce},     32'd1);
        chk("switch_count", {16'd0, step_count}, {16'd0, ec});
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk("fast_ce", {31'd0, cpu_ce}, (i % 4 == 0) ? 32'd1 : 32'd0);
        end
        ec = 16'd8;
        chk("fast_count", {16'd0, step_count}, {16'd0, ec});
        chk("fast_led",   {31'd0, tick_led},   {31'd0, ec[0]});

        // ---- 5: lock at the firing cycle
        mode_sel = 2'b00; cyc(1);
        mode_sel = 2'b10; cyc(1);
        cyc(9);
        chk("pre_lock_ce", {31'd0, cpu_ce}, 32'd0);
        halt_req = 1'b1; cyc(1);
        chk("lock_ce",    {31'd0, cpu_ce},     32'd0);
        chk("lock_state", {30'd0, state},      32'd3);
        chk("lock_count", {16'd0, step_count}, {16'd0, ec});
        step_req = 1'b1; cyc(1);
        chk("lock_step_ce",    {31'd0, cpu_ce}, 32'd0);
        chk("lock_step_state", {30'd0, state},  32'd3);
        step_req = 1'b0; halt_req = 1'b0; cyc(1);
        chk("lock_hold", {30'd0, state}, 32'd3);
        resume = 1'b1; cyc(1);
        chk("resume_halt", {30'd0, state}, 32'd0);
        cyc(1);
        chk("resume_run",  {30'd0, state}, 32'd1);
        resume = 1'b0; halt_req = 1'b1; cyc(1);
        chk("relock_a", {30'd0, state}, 32'd3);
        resume = 1'b1; cyc(1);
        chk("relock_halt", {30'd0, state}, 32'd0);
        cyc(1);
        chk("relock_b", {30'd0, state}, 32'd3);
        resume = 1'b0; halt_req = 1'b0; cyc(1);
        resume = 1'b1; cyc(1);
        chk("unlock", {30'd0, state}, 32'd0);
        resume = 1'b0;
        // step with halt_req raised during the STEP cycle
        mode_sel = 2'b01; step_req = 1'b1; cyc(1);
        ec = 16'd9;
        chk("hstep_ce",    {31'd0, cpu_ce},     32'd1);
        chk("hstep_count", {16'd0, step_count}, {16'd0, ec});
        halt_req = 1'b1; cyc(1);
        chk("hstep_lock",  {30'd0, state},      32'd3);
        chk("hstep_ce_off", {31'd0, cpu_ce},    32'd0);
        step_req = 1'b0; halt_req = 1'b0; mode_sel = 2'b00; cyc(1);

        // ---- 6: count wrap with DIV=1, async reset mid-run
        reset = 1'b0;
        #1;
        chk("rst2_count", {16'd0, w_step_count}, 32'd0);
        chk("rst2_state", {30'd0, w_state},      32'd0);
        @(negedge clk) reset = 1'b1;
        mode_sel = 2'b11;
        cyc(1);
        chk("wrap_entry",  {30'd0, w_state},  32'd1);
        chk("wrap_entry_ce", {31'd0, w_cpu_ce}, 32'd0);
        cyc(65535);
        chk("wrap_ffff",     {16'd0, w_step_count}, 32'h0000_ffff);
        chk("wrap_ffff_led", {31'd0, w_tick_led},   32'd1);
        cyc(1);
        chk("wrap_zero",     {16'd0, w_step_count}, 32'd0);
        chk("wrap_zero_led", {31'd0, w_tick_led},   32'd0);
        chk("wrap_ce",       {31'd0, w_cpu_ce},     32'd1);
        cyc(2);
        chk("wrap_two", {16'd0, w_step_count}, 32'd2);
        #3 reset = 1'b0;
        #1;
        chk("async_ce",    {31'd0, w_cpu_ce},     32'd0);
        chk("async_count", {16'd0, w_step_count}, 32'd0);
        chk("async_led",   {31'd0, w_tick_led},   32'd0);
        mode_sel = 2'b00;
        @(negedge clk) reset = 1'b1;
        cyc(2);
        chk("post_rst_ce", {31'd0, w_cpu_ce}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
